// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the later pipelined variant.
// Holds the bus widths, the PC increment and the fetch FSM state encoding.
package proc_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 4;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_VALID,
        ST_HALT
    } fetch_state_e;

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
// The master modport is the fetch unit; the slave side is memory plus decode.
interface fetch_unit_if;
    import proc_pkg::*;

    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              uncond_branch;
    logic              branch;
    logic              alu_zero;
    logic [ADDR_W-1:0] br_offset;

    modport master (
        output imem_addr, inst, inst_pc, inst_valid,
        input  imem_data, inst_ready, uncond_branch, branch, alu_zero, br_offset
    );

    modport slave (
        input  imem_addr, inst, inst_pc, inst_valid,
        output imem_data, inst_ready, uncond_branch, branch, alu_zero, br_offset
    );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Branch resolution to next PC: B beats CBZ, otherwise fall through by 4.
// Purely combinational; all arithmetic wraps at 2^64.
module next_pc_calc
    import proc_pkg::*;
(
    input  logic [ADDR_W-1:0] inst_pc,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              uncond_branch,
    input  logic              branch,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] next_pc,
    output logic              take
);

    assign take    = uncond_branch | (branch & alu_zero);
    assign next_pc = take ? inst_pc + (br_offset << 2) : inst_pc + PC_INC;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: issue address, wait MEM_WAIT cycles,
// capture the word, hand it to decode and resolve the next PC on accept.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int MEM_WAIT          = 2,
    parameter bit RESET_ALIGN_CHECK = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              stall,
    output logic              fault,
    fetch_unit_if.master      bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT - 1);

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] next_pc;
    logic              br_take;
    logic              accept;
    logic              enter_wait;
    logic [ADDR_W-1:0] wait_pc;

    next_pc_calc u_next_pc (
        .inst_pc       (inst_pc_q),
        .br_offset     (bus.br_offset),
        .uncond_branch (bus.uncond_branch),
        .branch        (bus.branch),
        .alu_zero      (bus.alu_zero),
        .next_pc       (next_pc),
        .take          (br_take)
    );

    // stall outranks inst_ready, so a stalled accept simply re-presents inst
    assign accept = (state_q == ST_VALID) && bus.inst_ready && !stall;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        enter_wait = 1'b0;
        wait_pc    = pc_q;

        if (!stall) begin
            unique case (state_q)
                ST_IDLE: enter_wait = 1'b1;
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        inst_d    = bus.imem_data;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        state_d   = ST_VALID;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_VALID: begin
                    if (bus.inst_ready) begin
                        valid_d    = 1'b0;
                        enter_wait = 1'b1;
                        wait_pc    = next_pc;
                    end
                end
                ST_HALT: ;
                default: state_d = ST_HALT;
            endcase
        end

        // Every WAIT entry issues a new address; a misaligned one parks in HALT
        if (enter_wait) begin
            pc_d   = wait_pc;
            addr_d = wait_pc;
            if (RESET_ALIGN_CHECK && misaligned(wait_pc)) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pc_q      <= start_pc;
            addr_q    <= start_pc;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.imem_addr  = addr_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = valid_q;
    assign fault          = fault_q;

    a_seq_advance: assert property (@(posedge CLK) disable iff (!Reset_L)
        (accept && !br_take) |=> (pc_q == $past(inst_pc_q) + PC_INC));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: branch-resolution vector table plus sequences
// for latency, backpressure, stall, mid-read reset, misalignment and MEM_WAIT=1.
module tb_fetch_unit;
    import proc_pkg::*;

    logic              CLK = 1'b0;
    logic              Reset_L = 1'b0;
    logic [ADDR_W-1:0] start_pc = '0;
    logic              stall = 1'b0;
    logic              fault0, fault1;
    int                checks = 0;
    int                errors = 0;

    fetch_unit_if bus0();
    fetch_unit_if bus1();

    fetch_unit #(.MEM_WAIT(2), .RESET_ALIGN_CHECK(1'b1)) dut0 (
        .CLK(CLK), .Reset_L(Reset_L), .start_pc(start_pc), .stall(stall),
        .fault(fault0), .bus(bus0)
    );

    fetch_unit #(.MEM_WAIT(1), .RESET_ALIGN_CHECK(1'b1)) dut1 (
        .CLK(CLK), .Reset_L(Reset_L), .start_pc(start_pc), .stall(stall),
        .fault(fault1), .bus(bus1)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:    return 32'hF840_03E9;
            64'h4:    return 32'hF840_83EA;
            64'h34:   return 32'hD29B_DE0A;
            default:  return a[31:0] ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign bus0.imem_data = mem_word(bus0.imem_addr);
    assign bus1.imem_data = mem_word(bus1.imem_addr);

    typedef struct {
        logic [63:0] pc;
        logic        ub;
        logic        br;
        logic        z;
        logic [63:0] off;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_br();
        bus0.uncond_branch = 1'b0;
        bus0.branch        = 1'b0;
        bus0.alu_zero      = 1'b0;
        bus0.br_offset     = '0;
    endtask

    // Count rising edges until inst_valid, bounded so a dead DUT still fails
    task automatic wait_valid(input bit which, output int n);
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (which ? bus1.inst_valid : bus0.inst_valid) break;
        end
    endtask

    task automatic do_reset(input logic [63:0] pc);
        Reset_L = 1'b0;
        start_pc = pc;
        bus0.inst_ready = 1'b0;
        bus1.inst_ready = 1'b0;
        stall = 1'b0;
        clear_br();
        #2;
        chk("rst_addr", bus0.imem_addr, pc);
        chk("rst_inst", {32'h0, bus0.inst}, 64'h0);
        chk("rst_inst_pc", bus0.inst_pc, 64'h0);
        chk("rst_valid", {63'h0, bus0.inst_valid}, 64'h0);
        chk("rst_fault", {63'h0, fault0}, 64'h0);
        step();
        Reset_L = 1'b1;
    endtask

    initial begin
        int n;
        bus1.uncond_branch = 1'b0;
        bus1.branch        = 1'b0;
        bus1.alu_zero      = 1'b0;
        bus1.br_offset     = '0;
        bus1.inst_ready    = 1'b0;
        bus0.inst_ready    = 1'b0;
        clear_br();

        vecs[0] = '{64'h1C, 1'b0, 1'b1, 1'b1, 64'd4, 64'h2C};
        vecs[1] = '{64'h1C, 1'b0, 1'b1, 1'b0, 64'd4, 64'h20};
        vecs[2] = '{64'h28, 1'b1, 1'b0, 1'b0, -64'sd3, 64'h1C};
        vecs[3] = '{64'h28, 1'b1, 1'b1, 1'b0, -64'sd3, 64'h1C};
        vecs[4] = '{64'h0, 1'b0, 1'b0, 1'b0, 64'd7, 64'h4};
        vecs[5] = '{64'h100, 1'b0, 1'b0, 1'b1, 64'd10, 64'h104};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 64'd0, 64'h0};
        vecs[7] = '{64'h4, 1'b1, 1'b0, 1'b0, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[8] = '{64'h40, 1'b1, 1'b0, 1'b0, 64'd0, 64'h40};

        // Sequential fetch and first-valid latency
        do_reset(64'h0);
        wait_valid(1'b0, n);
        chk("first_lat", 64'(n), 64'd3);
        chk("first_inst", {32'h0, bus0.inst}, 64'hF840_03E9);
        chk("first_pc", bus0.inst_pc, 64'h0);
        bus0.inst_ready = 1'b1;
        step();
        chk("acc_addr", bus0.imem_addr, 64'h4);
        chk("acc_valid", {63'h0, bus0.inst_valid}, 64'h0);
        bus0.inst_ready = 1'b0;
        wait_valid(1'b0, n);
        chk("seq_lat", 64'(n), 64'd2);
        chk("seq_inst", {32'h0, bus0.inst}, 64'hF840_83EA);
        chk("seq_pc", bus0.inst_pc, 64'h4);

        // Backpressure: everything holds while inst_ready is low
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {bus0.inst, bus0.inst_pc[15:0], bus0.imem_addr[14:0], bus0.inst_valid},
                {32'hF840_83EA, 16'h4, 15'h4, 1'b1});
        end

        // Stall beats inst_ready, then a single advance on release
        stall = 1'b1;
        bus0.inst_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_valid", {63'h0, bus0.inst_valid}, 64'h1);
            chk("stall_addr", bus0.imem_addr, 64'h4);
        end
        stall = 1'b0;
        step();
        chk("unstall_addr", bus0.imem_addr, 64'h8);
        chk("unstall_valid", {63'h0, bus0.inst_valid}, 64'h0);
        bus0.inst_ready = 1'b0;

        // Stall while waiting freezes the counter
        stall = 1'b1;
        repeat (3) step();
        chk("stall_wait_valid", {63'h0, bus0.inst_valid}, 64'h0);
        stall = 1'b0;
        wait_valid(1'b0, n);
        chk("stall_wait_lat", 64'(n), 64'd2);
        chk("stall_wait_pc", bus0.inst_pc, 64'h8);

        // Reset while a read is outstanding
        bus0.inst_ready = 1'b1;
        step();
        chk("mid_wait", {63'h0, bus0.inst_valid}, 64'h0);
        do_reset(64'h34);
        wait_valid(1'b0, n);
        chk("rst_mid_lat", 64'(n), 64'd3);
        chk("rst_mid_inst", {32'h0, bus0.inst}, 64'hD29B_DE0A);
        chk("rst_mid_pc", bus0.inst_pc, 64'h34);

        // Branch-resolution vectors
        foreach (vecs[i]) begin
            do_reset(vecs[i].pc);
            wait_valid(1'b0, n);
            chk("vec_pc", bus0.inst_pc, vecs[i].pc);
            bus0.inst_ready    = 1'b1;
            bus0.uncond_branch = vecs[i].ub;
            bus0.branch        = vecs[i].br;
            bus0.alu_zero      = vecs[i].z;
            bus0.br_offset     = vecs[i].off;
            step();
            bus0.inst_ready = 1'b0;
            clear_br();
            chk("vec_addr", bus0.imem_addr, vecs[i].exp);
            wait_valid(1'b0, n);
            chk("vec_next_pc", bus0.inst_pc, vecs[i].exp);
            chk("vec_next_inst", {32'h0, bus0.inst}, {32'h0, mem_word(vecs[i].exp)});
        end

        // Misaligned start halts with a sticky fault
        do_reset(64'h2);
        step();
        chk("mis_fault", {63'h0, fault0}, 64'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mis_hold", {fault0, bus0.inst_valid, bus0.imem_addr[61:0]}, {1'b1, 1'b0, 62'h2});
        end
        do_reset(64'h0);

        // MEM_WAIT = 1 latencies
        wait_valid(1'b1, n);
        chk("mw1_first_lat", 64'(n), 64'd2);
        chk("mw1_first_inst", {32'h0, bus1.inst}, 64'hF840_03E9);
        bus1.inst_ready = 1'b1;
        step();
        bus1.inst_ready = 1'b0;
        chk("mw1_addr", bus1.imem_addr, 64'h4);
        wait_valid(1'b1, n);
        chk("mw1_seq_lat", 64'(n), 64'd1);
        chk("mw1_seq_pc", bus1.inst_pc, 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the instruction memory address.
- Waits a fixed number of cycles for read data, then captures the 32-bit word into an instruction register.
- Presents the word to decode/control with a valid/ready handshake. Computes the next PC from the branch resolution returned on the accept cycle (sequential, B, CBZ).

Parameters:
- MEM_WAIT, 2, cycles from imem_addr change to imem_data being sampled; legal range 1..15.
- RESET_ALIGN_CHECK, 1, when 1 a misaligned PC (pc[1:0] != 0) raises fault.

Ports:
- CLK  in  1  single clock, rising edge
- Reset_L  in  1  asynchronous, active-low reset
- start_pc  in  64  PC loaded while Reset_L is low
- stall  in  1  freezes the FSM and counter; outputs hold
- imem_addr  out  64  address to instruction memory
- imem_data  in  32  read data from instruction memory
- inst  out  32  captured instruction
- inst_pc  out  64  PC of inst
- inst_valid  out  1  inst/inst_pc are valid
- inst_ready  in  1  decode accepts inst this cycle
- uncond_branch  in  1  B resolved; sampled on the accept cycle only
- branch  in  1  CBZ resolved; sampled on the accept cycle only
- alu_zero  in  1  CBZ operand is zero; sampled on the accept cycle only
- br_offset  in  64  sign-extended word offset, already extended by decode
- fault  out  1  sticky misaligned-PC flag

Behaviour:
- Reset (Reset_L low, asynchronous):
  - pc = start_pc; imem_addr = start_pc.
  - inst = 32'h0, inst_pc = 0, inst_valid = 0, fault = 0.
  - Wait counter = 0; state = IDLE.
- States: IDLE, WAIT, VALID, HALT.
- IDLE:
  - First clock after reset release goes to WAIT.
  - Counter loads MEM_WAIT-1; imem_addr = pc.
- WAIT:
  - Counter decrements each unstalled cycle.
  - When counter == 0: inst <= imem_data, inst_pc <= pc, inst_valid <= 1, go to VALID.
  - Latency: address-to-inst_valid = MEM_WAIT cycles; reset-release-to-first-valid = MEM_WAIT+1 cycles.
- VALID:
  - inst/inst_pc hold stable while inst_ready is low (no overwrite, no re-fetch).
  - Accept = inst_valid & inst_ready. On accept:
    - take = uncond_branch | (branch & alu_zero).
    - next = take ? inst_pc + (br_offset << 2) : inst_pc + 4, using 64-bit wrapping arithmetic (wrap at 2^64, no flag).
    - pc <= next; imem_addr <= next; inst_valid <= 0; counter <= MEM_WAIT-1; go to WAIT.
  - uncond_branch has priority: when it is 1, branch and alu_zero are ignored.
  - Branch inputs are don't-care outside the accept cycle.
  - Result: one instruction in flight, no speculation, no flush logic needed.
- stall:
  - When high in any state, state, counter, pc and all outputs hold.
  - An accept in the same cycle is ignored: inst_valid stays 1 and the same inst is re-presented.
  - stall has priority over inst_ready.
- Misalignment:
  - With RESET_ALIGN_CHECK=1, if pc[1:0] != 0 on entry to WAIT (including after reset), fault <= 1, inst_valid stays 0, state = HALT.
  - HALT is left only via reset. imem_addr holds the offending pc.
- Reset mid-operation (any state): immediate return to reset values. Any partially waited read is discarded.
- MEM_WAIT = 1: WAIT lasts exactly one cycle; data is sampled on the cycle after the address changes.

Decomposition:
- Shared package (proc_pkg): fetch state enum, INST_W=32, ADDR_W=64, PC_INC=64'd4.
- Optional sub-module next_pc_calc (combinational: inst_pc, br_offset, uncond_branch, branch, alu_zero -> next_pc, take). It is reused by the pipelined variant later.
- Counter and FSM stay in fetch_unit.

Test Plan:
- Sequential fetch: start_pc=0, memory returns F84003E9 @0 and F84083EA @4, inst_ready=1, MEM_WAIT=2 -> inst_valid after 3 cycles with inst=F84003E9, inst_pc=0; next inst F84083EA, inst_pc=4, 2 cycles after accept.
- CBZ taken: accept at inst_pc=0x1C with branch=1, alu_zero=1, br_offset=4 -> imem_addr=0x2C. Same with alu_zero=0 -> imem_addr=0x20.
- Unconditional backward: accept at inst_pc=0x28, uncond_branch=1, br_offset=-3 -> imem_addr=0x1C. With branch=1, alu_zero=0 also set -> still 0x1C.
- Backpressure and stall:
  - inst_ready=0 for 5 cycles -> inst and inst_pc unchanged, imem_addr unchanged.
  - stall=1 together with inst_ready=1 -> no advance; release stall -> single advance to pc+4.
- Reset mid-WAIT: Reset_L low one cycle while counter=1, start_pc=0x34 -> outputs cleared immediately; first inst_valid at inst_pc=0x34 (D29BDE0A) MEM_WAIT+1 cycles after release.
- Misaligned: start_pc=0x2 -> fault=1 on the first WAIT entry, inst_valid never rises, fault stays 1 until reset.
